// File: rtl/slave_mem_subsystem.sv
// Node-walking subsystem: a 32 x 12-bit node ring, a slave walker that marks
// each visited node, and a 2:1 port mux that lets an external master take over.
module slave_mem_subsystem #(
  parameter int ADDR_W     = 5,
  parameter int NODE_W     = 12,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              master_has_control,
  input  logic [ADDR_W-1:0] master_read_addr,
  input  logic [ADDR_W-1:0] master_write_addr,
  input  logic              master_write,
  input  logic [NODE_W-1:0] master_write_node,
  output logic [NODE_W-1:0] read_node,
  output logic              slave_done,
  output logic [ADDR_W:0]   slave_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {WALK, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   w_nextPtr;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_nextCount;
  logic [NODE_W-1:0]   r_mem [DEPTH];

  logic                w_slaveWrite;
  logic [NODE_W-1:0]   w_slaveNode;
  logic [ADDR_W-1:0]   w_readAddr;
  logic [ADDR_W-1:0]   w_writeAddr;
  logic                w_write;
  logic [NODE_W-1:0]   w_writeNode;
  logic [NODE_W-1:0]   w_readNode;

  // Port mux fields are selected individually so the read path never loops
  // through the slave's write-side logic.
  assign w_readAddr  = master_has_control ? master_read_addr  : r_ptr;
  assign w_writeAddr = master_has_control ? master_write_addr : r_ptr;
  assign w_write     = master_has_control ? master_write      : w_slaveWrite;
  assign w_writeNode = master_has_control ? master_write_node : w_slaveNode;

  assign w_readNode  = r_mem[w_readAddr];
  assign read_node   = w_readNode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {2'b00, ADDR_W'(i + 1), ADDR_W'(i)};
      end
    end else if (w_write) begin
      r_mem[w_writeAddr] <= w_writeNode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WALK;
      r_ptr   <= ADDR_W'(START_ADDR);
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_ptr   <= w_nextPtr;
      r_count <= w_nextCount;
    end
  end

  assign w_slaveNode = {1'b1, w_readNode[NODE_W-2:0]};

  // The slave only advances while it owns the port, so a resumed walk
  // re-reads mem[ptr] and sees any master edits.
  always_comb begin
    w_nextState  = r_state;
    w_nextPtr    = r_ptr;
    w_nextCount  = r_count;
    w_slaveWrite = 1'b0;
    if (!master_has_control && r_state == WALK) begin
      if (!w_readNode[NODE_W-1]) begin
        w_slaveWrite = 1'b1;
        w_nextPtr    = w_readNode[2*ADDR_W-1:ADDR_W];
        if (r_count != '1) begin
          w_nextCount = r_count + 1'b1;
        end
      end else begin
        w_nextState = DONE;
      end
    end
  end

  assign slave_done  = (r_state == DONE);
  assign slave_count = r_count;

endmodule

// File: tb/tb_slave_mem_subsystem.sv
// Directed bench for slave_mem_subsystem: expected values are queued as each
// step is driven and popped when the corresponding output is sampled.
module tb_slave_mem_subsystem;

  logic        clk;
  logic        reset;
  logic        master_has_control;
  logic [4:0]  master_read_addr;
  logic [4:0]  master_write_addr;
  logic        master_write;
  logic [11:0] master_write_node;
  logic [11:0] read_node;
  logic        slave_done;
  logic [5:0]  slave_count;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  passCount  = 0;
  int  totalCount = 0;

  slave_mem_subsystem dut (
    .clk                (clk),
    .reset              (reset),
    .master_has_control (master_has_control),
    .master_read_addr   (master_read_addr),
    .master_write_addr  (master_write_addr),
    .master_write       (master_write),
    .master_write_node  (master_write_node),
    .read_node          (read_node),
    .slave_done         (slave_done),
    .slave_count        (slave_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on ring contents: next = i+1 mod 32, value = i, unmarked.
  function automatic logic [11:0] ringNode(input int i);
    logic [4:0] nxt;
    logic [4:0] val;
    nxt = 5'(i + 1);
    val = 5'(i);
    return {2'b00, nxt, val};
  endfunction

  task automatic expectVal(input string tag, input logic [11:0] v);
    sb_t item;
    item.tag = tag;
    item.exp = v;
    sbq.push_back(item);
  endtask

  task automatic checkOutput(input logic [11:0] obs);
    sb_t item;
    totalCount++;
    if (sbq.size() == 0) begin
      $error("[TB] FAIL scoreboard-empty observed=%h expected=none", obs);
    end else begin
      item = sbq.pop_front();
      assert (obs === item.exp) passCount++;
      else $error("[TB] FAIL %s observed=%h expected=%h", item.tag, obs, item.exp);
    end
  endtask

  task automatic applyStimulus(input logic ctrl, input logic [4:0] raddr,
                               input logic [4:0] waddr, input logic wr,
                               input logic [11:0] wnode);
    master_has_control = ctrl;
    master_read_addr   = raddr;
    master_write_addr  = waddr;
    master_write       = wr;
    master_write_node  = wnode;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkCount(input string tag, input int v);
    expectVal(tag, 12'(v));
    checkOutput({6'b0, slave_count});
  endtask

  task automatic checkDone(input string tag, input logic v);
    expectVal(tag, {11'b0, v});
    checkOutput({11'b0, slave_done});
  endtask

  task automatic masterRead(input string tag, input logic [4:0] a, input logic [11:0] v);
    applyStimulus(1'b1, a, 5'd0, 1'b0, 12'h000);
    #1;
    expectVal(tag, v);
    checkOutput(read_node);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 12'h000);

    // Test 1: full walk of the default ring.
    pulseReset();
    #1;
    checkCount("t1-reset-count", 0);
    checkDone("t1-reset-done", 1'b0);
    for (int e = 1; e <= 32; e++) begin
      stepEdges(1);
      checkCount($sformatf("t1-count-e%0d", e), e);
    end
    checkDone("t1-done-e32", 1'b0);
    stepEdges(1);
    checkDone("t1-done-e33", 1'b1);
    checkCount("t1-count-final", 32);
    masterRead("t1-mem3", 5'd3, ringNode(3) | 12'h800);

    // Test 2: master stalls the walk and plants a marked node at 20.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 12'h000);
    pulseReset();
    stepEdges(5);
    checkCount("t2-count-e5", 5);
    applyStimulus(1'b1, 5'd0, 5'd20, 1'b1, 12'hAB4);
    for (int e = 6; e <= 10; e++) begin
      stepEdges(1);
      checkCount($sformatf("t2-hold-e%0d", e), 5);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 12'h000);
    stepEdges(16);
    checkCount("t2-count-final", 20);
    checkDone("t2-done", 1'b1);
    masterRead("t2-mem19", 5'd19, ringNode(19) | 12'h800);
    masterRead("t2-mem21", 5'd21, ringNode(21));
    masterRead("t2-mem20", 5'd20, 12'hAB4);

    // Test 3: master turns node 0 into a self-loop before the slave starts.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 12'h000);
    pulseReset();
    stepEdges(1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 12'h000);
    stepEdges(1);
    checkDone("t3-done-e1", 1'b0);
    stepEdges(1);
    checkDone("t3-done", 1'b1);
    checkCount("t3-count", 1);
    masterRead("t3-mem0", 5'd0, 12'h800);

    // Test 4: asynchronous reset in the middle of a walk.
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 12'h000);
    pulseReset();
    stepEdges(10);
    checkCount("t4-count-e10", 10);
    #2;
    reset = 1'b1;
    #1;
    checkCount("t4-async-count", 0);
    checkDone("t4-async-done", 1'b0);
    expectVal("t4-async-mem0", ringNode(0));
    checkOutput(read_node);
    @(negedge clk);
    reset = 1'b0;
    stepEdges(33);
    checkCount("t4-count-final", 32);
    checkDone("t4-done", 1'b1);

    // Test 5: master edits node 1 (spare bit) before the slave visits it.
    applyStimulus(1'b1, 5'd0, 5'd1, 1'b1, 12'h442);
    pulseReset();
    stepEdges(1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 12'h000);
    stepEdges(33);
    checkCount("t5-count", 32);
    checkDone("t5-done", 1'b1);
    masterRead("t5-mem1", 5'd1, 12'hC42);

    // Test 6: same-address read and write returns old data first.
    applyStimulus(1'b1, 5'd7, 5'd7, 1'b1, 12'h123);
    pulseReset();
    #1;
    expectVal("t6-old", ringNode(7));
    checkOutput(read_node);
    stepEdges(1);
    master_write = 1'b0;
    expectVal("t6-new", 12'h123);
    checkOutput(read_node);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
